fpu_request_arbiter: RTL and testbench

- Shares one Fixed_Point_Unit between NUM_REQ requesters, e.g. the integer pipeline and the load/store path.
- Accepts one request at a time with a valid/ready handshake and registers the operands onto the FPU ports.
- Decides when the FPU result is valid: a stale ready level from a previous multi-cycle op is never taken as completion.
- Returns the result as a one-cycle response pulse tagged to the requester; a timeout guard covers a hung SQRT.

---
 rtl/fpu_request_arbiter.sv | 139 +++++++++++++
 tb/tb_fpu_request_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_request_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared Fixed_Point_Unit and returns tagged result pulses.
// Define FPU_ARB_FIXED_PRIORITY_EN for lowest-index-wins grants instead of round-robin.
module fpu_request_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int WIDTH    = 32,
  parameter int MUL_WAIT = 7,
  parameter int TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_1,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_2,
  input  logic [NUM_REQ*2-1:0]     req_operation,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_error,
  output logic                     busy,
  output logic [WIDTH-1:0]         fpu_operand_1,
  output logic [WIDTH-1:0]         fpu_operand_2,
  output logic [1:0]               fpu_operation,
  input  logic [WIDTH-1:0]         fpu_result,
  input  logic                     fpu_ready
);
  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      id_q, grant_id, cand;
  logic [NUM_REQ-1:0] grant;
  logic               grant_found, accept, complete, expire, fast_op;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   op1_arr [NUM_REQ];
  logic [WIDTH-1:0]   op2_arr [NUM_REQ];
  logic [1:0]         opc_arr [NUM_REQ];
`ifndef FPU_ARB_FIXED_PRIORITY_EN
  logic [IW-1:0]      ptr_q;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op1_arr[g] = req_operand_1[g*WIDTH +: WIDTH];
    assign op2_arr[g] = req_operand_2[g*WIDTH +: WIDTH];
    assign opc_arr[g] = req_operation[g*2 +: 2];
  end

  // Search order starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef FPU_ARB_FIXED_PRIORITY_EN
      cand = IW'(i);
`else
      cand = IW'((32'(ptr_q) + 32'd1 + i) % NUM_REQ);
`endif
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    grant[grant_id] = grant_found;
  end

  assign fast_op = (fpu_operation == FPU_ADD) || (fpu_operation == FPU_SUB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Multi-cycle ops ignore fpu_ready until MUL_WAIT, so a stale level from the previous op is never taken as done.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    busy      = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant_found) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (fpu_ready && (fast_op || count_q >= CW'(MUL_WAIT))) complete = 1'b1;
        else if (count_q == CW'(TIMEOUT - 1))                 expire   = 1'b1;
        if (complete || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      fpu_operation <= FPU_ADD;
      id_q          <= '0;
      count_q       <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
      resp_error    <= 1'b0;
`ifndef FPU_ARB_FIXED_PRIORITY_EN
      ptr_q         <= IW'(NUM_REQ - 1);
`endif
    end else begin
      resp_valid <= '0;
      if (accept) begin
        fpu_operand_1 <= op1_arr[grant_id];
        fpu_operand_2 <= op2_arr[grant_id];
        fpu_operation <= opc_arr[grant_id];
        id_q          <= grant_id;
        count_q       <= '0;
`ifndef FPU_ARB_FIXED_PRIORITY_EN
        ptr_q         <= grant_id;
`endif
      end else if (state_q == WAIT) begin
        if (count_q != CW'(TIMEOUT)) count_q <= count_q + 1'b1;
        if (complete || expire) begin
          resp_valid[id_q] <= 1'b1;
          resp_result      <= complete ? fpu_result : '0;
          resp_error       <= expire;
          fpu_operation    <= FPU_ADD;
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Bench for fpu_request_arbiter: directed vector table, reset-mid-op sequence, random transactions.
// Honours FPU_ARB_FIXED_PRIORITY_EN when choosing expected grants.
module tb_fpu_request_arbiter;
  localparam int N        = 2;
  localparam int W        = 32;
  localparam int MUL_WAIT = 7;
  localparam int TIMEOUT  = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, resp_valid;
  logic [N*W-1:0] req_operand_1, req_operand_2;
  logic [N*2-1:0] req_operation;
  logic [W-1:0]   resp_result, fpu_operand_1, fpu_operand_2, fpu_result;
  logic           resp_error, busy, fpu_ready;
  logic [1:0]     fpu_operation;

  int checks = 0;
  int errors = 0;
  int last   = N - 1;

  fpu_request_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_WAIT(MUL_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_operand_1(req_operand_1),
    .req_operand_2(req_operand_2), .req_operation(req_operation), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_error(resp_error), .busy(busy),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready)
  );

  always #5 clk = ~clk;

  // Behavioural FPU model with 10 fractional bits; SQRT uses a simple bit-mixing function.
  function automatic logic [W-1:0] fpu_func(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return p[41:10];
      default: return (a >> 1) ^ 32'h5A5A;
    endcase
  endfunction

  assign fpu_result = fpu_func(fpu_operation, fpu_operand_1, fpu_operand_2);

  function automatic int pick(input logic [N-1:0] mask, input int prev);
`ifdef FPU_ARB_FIXED_PRIORITY_EN
    for (int d = 0; d < N; d++) if (mask[d]) return d;
    return prev;
`else
    for (int d = 1; d <= N; d++) if (mask[(prev + d) % N]) return (prev + d) % N;
    return prev;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present a request set in IDLE, check the grant, then follow the op to its response edge.
  task automatic run_txn(input string name, input logic [N-1:0] mask, input int w, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int r, input int lat,
                         input logic [W-1:0] res, input logic err);
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_operand_1[i*W +: W] = (i == w) ? a : (32'hDEAD_0000 | 32'(i));
      req_operand_2[i*W +: W] = (i == w) ? b : 32'h0BAD_0000;
      req_operation[i*2 +: 2] = (i == w) ? op : 2'b11;
    end
    fpu_ready = (r == 0);
    #1;
    check({name, " grant"}, 64'(req_ready), 64'(1 << w));
    @(posedge clk); #1;
    req_valid = mask & ~N'(1 << w);
    check({name, " busy"}, 64'(busy), 64'(1));
    check({name, " ready_in_wait"}, 64'(req_ready), 64'(0));
    check({name, " fpu_op1"}, 64'(fpu_operand_1), 64'(a));
    check({name, " fpu_op2"}, 64'(fpu_operand_2), 64'(b));
    check({name, " fpu_opc"}, 64'(fpu_operation), 64'(op));
    for (int k = 1; k <= lat; k++) begin
      fpu_ready = (k >= r);
      @(posedge clk); #1;
      if (k < lat) begin
        check({name, " early_resp"}, 64'(resp_valid), 64'(0));
        if (k == lat - 1) check({name, " op1_stable"}, 64'(fpu_operand_1), 64'(a));
      end else begin
        check({name, " resp_valid"}, 64'(resp_valid), 64'(1 << w));
        check({name, " resp_result"}, 64'(resp_result), 64'(res));
        check({name, " resp_error"}, 64'(resp_error), 64'(err));
        check({name, " parked_opc"}, 64'(fpu_operation), 64'(0));
        check({name, " idle_busy"}, 64'(busy), 64'(0));
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           w_rr;
    int           w_fx;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           r;
    int           lat;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{2'b01, 0, 0, 2'b00, 32'h400, 32'h800,    0,  1, 32'hC00,  1'b0};
    tbl[1] = '{2'b10, 1, 1, 2'b10, 32'h600, 32'h800,    1,  8, 32'hC00,  1'b0};
    tbl[2] = '{2'b11, 0, 0, 2'b00, 32'h100, 32'h200,    0,  1, 32'h300,  1'b0};
    tbl[3] = '{2'b11, 1, 0, 2'b00, 32'h111, 32'h222,    1,  1, 32'h333,  1'b0};
    tbl[4] = '{2'b11, 0, 0, 2'b01, 32'h900, 32'h100,    2,  2, 32'h800,  1'b0};
    tbl[5] = '{2'b11, 1, 0, 2'b00, 32'h001, 32'h002,    0,  1, 32'h003,  1'b0};
    tbl[6] = '{2'b01, 0, 0, 2'b11, 32'h400, 32'h000, 1000, 64, 32'h0,    1'b1};
    tbl[7] = '{2'b10, 1, 1, 2'b10, 32'h800, 32'h800,    0,  8, 32'h1000, 1'b0};
    tbl[8] = '{2'b01, 0, 0, 2'b00, 32'h010, 32'h020,    0,  1, 32'h030,  1'b0};
    tbl[9] = '{2'b01, 0, 0, 2'b00, 32'h030, 32'h040,    0,  1, 32'h070,  1'b0};

    reset = 1'b0;
    req_valid = '0;
    req_operand_1 = '0;
    req_operand_2 = '0;
    req_operation = '0;
    fpu_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst resp_valid", 64'(resp_valid), 64'(0));
    check("rst fpu_opc", 64'(fpu_operation), 64'(0));
    check("rst fpu_op1", 64'(fpu_operand_1), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
`ifdef FPU_ARB_FIXED_PRIORITY_EN
      run_txn($sformatf("vec%0d", i), tbl[i].mask, tbl[i].w_fx, tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].r, tbl[i].lat, tbl[i].res, tbl[i].err);
`else
      run_txn($sformatf("vec%0d", i), tbl[i].mask, tbl[i].w_rr, tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].r, tbl[i].lat, tbl[i].res, tbl[i].err);
`endif
    end

    // Reset during a MUL: the op must vanish without any response.
    req_valid = 2'b01;
    req_operand_1[0 +: W] = 32'h600;
    req_operand_2[0 +: W] = 32'h800;
    req_operation[0 +: 2] = 2'b10;
    fpu_ready = 1'b1;
    #1;
    check("rstmid grant", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rstmid busy", 64'(busy), 64'(0));
    check("rstmid resp_valid", 64'(resp_valid), 64'(0));
    check("rstmid result", 64'(resp_result), 64'(0));
    check("rstmid error", 64'(resp_error), 64'(0));
    check("rstmid fpu_opc", 64'(fpu_operation), 64'(0));
    check("rstmid fpu_op1", 64'(fpu_operand_1), 64'(0));
    check("rstmid fpu_op2", 64'(fpu_operand_2), 64'(0));
    check("rstmid req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("rstmid no_resp", 64'(resp_valid), 64'(0));
    end
    last = N - 1;
    run_txn("post_reset", 2'b11, 0, 2'b00, 32'h123, 32'h456, 0, 1, 32'h579, 1'b0);
    last = 0;

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] mask;
      logic [1:0]   op;
      logic [W-1:0] a, b, res;
      int           w, r, lat;
      logic         err;
      mask = N'($urandom_range(1, (1 << N) - 1));
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      r    = $urandom_range(0, 12);
      if (op == 2'b11 && $urandom_range(0, 5) == 0) r = 1000;
      w    = pick(mask, last);
      lat  = op[1] ? ((r > MUL_WAIT + 1) ? r : MUL_WAIT + 1) : ((r > 1) ? r : 1);
      if (lat > TIMEOUT) begin
        lat = TIMEOUT;
        res = '0;
        err = 1'b1;
      end else begin
        res = fpu_func(op, a, b);
        err = 1'b0;
      end
      run_txn($sformatf("rnd%0d", t), mask, w, op, a, b, r, lat, res, err);
      last = w;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
